// File: rtl/aig_tt_decoder.sv
// Streams AND nodes of a 4-input AIG, simulates each over all 16 minterms, emits the output literal's truth table.
// Latency: 1 cycle from last-beat handshake to tt_valid; one node per cycle. Backpressure: node_ready drops while a result waits for tt_ready.
module aig_tt_decoder #(
    parameter int MAX_NODES = 16,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             node_valid,
    output logic             node_ready,
    input  logic [IDX_W:0]   node_a,
    input  logic [IDX_W:0]   node_b,
    input  logic             node_last,
    output logic             tt_valid,
    input  logic             tt_ready,
    output logic [15:0]      tt_data,
    output logic [IDX_W-1:0] tt_nodes,
    output logic             tt_err
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] count_q;
    logic             err_q;
    logic             tt_valid_q;
    logic [15:0]      tt_data_q;
    logic [IDX_W-1:0] tt_nodes_q;
    logic             tt_err_q;
    logic [15:0]      node_tt_q [MAX_NODES];

    logic [IDX_W-1:0] idx_a, idx_b;
    logic             cmp_a, cmp_b;
    logic [IDX_W:0]   idx_limit;
    logic             a_bad, b_bad, table_full;
    logic [15:0]      base_a, base_b, tt_a, tt_b;
    logic             accept, node_ok;

    function automatic logic [15:0] fixed_tt(input logic [2:0] idx);
        case (idx)
            3'd1:    fixed_tt = 16'hAAAA;
            3'd2:    fixed_tt = 16'hCCCC;
            3'd3:    fixed_tt = 16'hF0F0;
            3'd4:    fixed_tt = 16'hFF00;
            default: fixed_tt = 16'h0000;
        endcase
    endfunction

    assign idx_a = node_a[IDX_W:1];
    assign cmp_a = node_a[0];
    assign idx_b = node_b[IDX_W:1];
    assign cmp_b = node_b[0];

    // A literal is valid only if it names a constant, a primary input or an already-built node.
    assign idx_limit  = (IDX_W+1)'(count_q) + (IDX_W+1)'(5);
    assign a_bad      = {1'b0, idx_a} >= idx_limit;
    assign b_bad      = {1'b0, idx_b} >= idx_limit;
    assign table_full = int'(count_q) >= MAX_NODES;

    always_comb begin
        base_a = 16'h0000;
        base_b = 16'h0000;
        if (idx_a < IDX_W'(5)) base_a = fixed_tt(idx_a[2:0]);
        if (idx_b < IDX_W'(5)) base_b = fixed_tt(idx_b[2:0]);
        for (int n = 0; n < MAX_NODES; n++) begin
            if (int'(idx_a) == n + 5) base_a = node_tt_q[n];
            if (int'(idx_b) == n + 5) base_b = node_tt_q[n];
        end
    end

    assign tt_a = base_a ^ {16{cmp_a}};
    assign tt_b = base_b ^ {16{cmp_b}};

    assign node_ready = (state_q == ST_LOAD);
    assign accept     = node_valid && node_ready;
    assign node_ok    = accept && !node_last && !a_bad && !b_bad && !table_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            count_q    <= '0;
            err_q      <= 1'b0;
            tt_valid_q <= 1'b0;
            tt_data_q  <= 16'h0000;
            tt_nodes_q <= '0;
            tt_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        if (node_last) begin
                            tt_data_q  <= tt_a;
                            tt_nodes_q <= count_q;
                            tt_err_q   <= err_q | a_bad;
                            tt_valid_q <= 1'b1;
                            state_q    <= ST_OUT;
                        end else if (node_ok) begin
                            count_q <= count_q + IDX_W'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (tt_ready) begin
                        tt_valid_q <= 1'b0;
                        count_q    <= '0;
                        err_q      <= 1'b0;
                        state_q    <= ST_LOAD;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // Stale entries need no clearing: the index check makes them unreachable.
    always_ff @(posedge clk) begin
        for (int n = 0; n < MAX_NODES; n++) begin
            if (node_ok && int'(count_q) == n) node_tt_q[n] <= tt_a & tt_b;
        end
    end

    assign tt_valid = tt_valid_q;
    assign tt_data  = tt_data_q;
    assign tt_nodes = tt_nodes_q;
    assign tt_err   = tt_err_q;

endmodule

// File: tb/tb_aig_tt_decoder.sv
// Directed bench for aig_tt_decoder with hand-computed truth tables.
module tb_aig_tt_decoder;

    localparam int MAX_NODES = 16;
    localparam int IDX_W     = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             node_valid = 1'b0;
    logic             node_ready;
    logic [IDX_W:0]   node_a = '0;
    logic [IDX_W:0]   node_b = '0;
    logic             node_last = 1'b0;
    logic             tt_valid;
    logic             tt_ready = 1'b0;
    logic [15:0]      tt_data;
    logic [IDX_W-1:0] tt_nodes;
    logic             tt_err;

    int n_cmp  = 0;
    int n_fail = 0;

    aig_tt_decoder #(.MAX_NODES(MAX_NODES), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .node_valid (node_valid),
        .node_ready (node_ready),
        .node_a     (node_a),
        .node_b     (node_b),
        .node_last  (node_last),
        .tt_valid   (tt_valid),
        .tt_ready   (tt_ready),
        .tt_data    (tt_data),
        .tt_nodes   (tt_nodes),
        .tt_err     (tt_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input int a, input int b, input bit last);
        bit done = 0;
        node_a     = (IDX_W+1)'(a);
        node_b     = (IDX_W+1)'(b);
        node_last  = last;
        node_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (node_ready) done = 1;
            @(negedge clk);
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        if (last) begin
            node_valid = 1'b0;
            node_last  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        node_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic get_result(input string tag, input logic [15:0] exp_data,
                              input int exp_nodes, input bit exp_err);
        for (int i = 0; i < 20 && !tt_valid; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(tt_valid), 32'd1);
        check({tag, "_data"},  32'(tt_data), 32'(exp_data));
        check({tag, "_nodes"}, 32'(tt_nodes), 32'(exp_nodes));
        check({tag, "_err"},   32'(tt_err), 32'(exp_err));
        check({tag, "_nrdy"},  32'(node_ready), 32'd0);
        tt_ready = 1'b1;
        @(negedge clk);
        tt_ready = 1'b0;
        check({tag, "_vld_clr"}, 32'(tt_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(node_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tt_valid", 32'(tt_valid), 32'd0);
        check("rst_tt_data",  32'(tt_data), 32'd0);
        check("rst_tt_nodes", 32'(tt_nodes), 32'd0);
        check("rst_tt_err",   32'(tt_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_node_ready", 32'(node_ready), 32'd1);

        // x1 & x3 = CC00; last beat latency is one cycle
        send(4, 8, 0);
        check("lat_pre", 32'(tt_valid), 32'd0);
        send(10, 0, 1);
        check("lat_1cyc", 32'(tt_valid), 32'd1);
        get_result("and1", 16'hCC00, 1, 0);

        send(4, 8, 0);
        send(11, 0, 1);
        get_result("and1_inv", 16'h33FF, 1, 0);

        send(1, 0, 1);
        get_result("const1", 16'hFFFF, 0, 0);

        send(4, 0, 1);
        get_result("pi_x1", 16'hCCCC, 0, 0);

        // XOR(x0,x1) from three ANDs, back-to-back beats
        send(2, 5, 0);
        send(3, 4, 0);
        send(11, 13, 0);
        send(15, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(tt_valid), 32'd1);
            check("bp_data",  32'(tt_data), 32'h6666);
            check("bp_nodes", 32'(tt_nodes), 32'd3);
            check("bp_err",   32'(tt_err), 32'd0);
            check("bp_nrdy",  32'(node_ready), 32'd0);
            @(negedge clk);
        end
        get_result("xor", 16'h6666, 3, 0);

        // x0 & x1 = 8888, complemented -> 7777
        send(2, 4, 0);
        send(11, 0, 1);
        get_result("nand", 16'h7777, 1, 0);

        // unknown index 6 on first node
        send(12, 2, 0);
        send(2, 0, 1);
        get_result("err_fwd", 16'hAAAA, 0, 1);

        send(1, 0, 1);
        get_result("after_err", 16'hFFFF, 0, 0);

        // self reference
        send(10, 2, 0);
        send(4, 0, 1);
        get_result("err_self", 16'hCCCC, 0, 1);

        // error on the output literal itself
        send(2, 4, 0);
        send(12, 0, 1);
        check("err_out_flag", 32'(tt_err), 32'd1);
        get_result("err_out", tt_data, 1, 1);

        // one node too many
        for (int i = 0; i < MAX_NODES + 1; i++) send(2, 4, 0);
        send(10, 0, 1);
        get_result("overflow", 16'h8888, MAX_NODES, 1);

        send(4, 8, 0);
        send(10, 0, 1);
        get_result("after_ovf", 16'hCC00, 1, 0);

        // reset mid-stream discards the partial netlist
        send(2, 4, 0);
        send(4, 8, 0);
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_valid", 32'(tt_valid), 32'd0);
        check("mrst_ready", 32'(node_ready), 32'd1);
        send(4, 8, 0);
        send(10, 0, 1);
        get_result("post_rst", 16'hCC00, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
